// File: rtl/uff_pkg.sv
// Shared mode encodings and SR conflict policy for the universal flip-flop bank.
// Build option UFF_SR_SET_PRIORITY_EN: SR S=R=1 sets the bit instead of flagging it.
package uff_pkg;

  typedef logic [1:0] mode_t;

  localparam mode_t MODE_SR = 2'd0;
  localparam mode_t MODE_JK = 2'd1;
  localparam mode_t MODE_D  = 2'd2;
  localparam mode_t MODE_T  = 2'd3;

`ifdef UFF_SR_SET_PRIORITY_EN
  localparam bit SR_SET_PRIORITY = 1'b1;
`else
  localparam bit SR_SET_PRIORITY = 1'b0;
`endif

  // True when this bit would raise an illegal event on an enabled edge.
  function automatic logic sr_conflict(input mode_t m, input logic s, input logic r);
    return (m == MODE_SR) && s && r && !SR_SET_PRIORITY;
  endfunction

endpackage

// File: rtl/uff_bit.sv
// One flip-flop bit with run-time SR/JK/D/T behaviour and an illegal-input flag.
// Latency: q and illegal update one edge after the inputs are sampled.
// Backpressure: none; En=0 holds q and clears illegal.
module uff_bit
  import uff_pkg::*;
(
  input  logic  Clk,
  input  logic  Rst,
  input  logic  En,
  input  mode_t Mode,
  input  logic  a,
  input  logic  b,
  input  logic  rst_val,
  output logic  q,
  output logic  illegal
);

  logic q_nxt;
  logic ill_nxt;

  always_comb begin
    q_nxt   = q;
    ill_nxt = sr_conflict(Mode, a, b);
    case (Mode)
      MODE_SR: begin
        if (a && b)      q_nxt = SR_SET_PRIORITY ? 1'b1 : q;
        else if (a)      q_nxt = 1'b1;
        else if (b)      q_nxt = 1'b0;
      end
      MODE_JK: begin
        case ({a, b})
          2'b10:   q_nxt = 1'b1;
          2'b01:   q_nxt = 1'b0;
          2'b11:   q_nxt = ~q;
          default: q_nxt = q;
        endcase
      end
      MODE_D:  q_nxt = a;
      default: q_nxt = a ? ~q : q;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      q       <= rst_val;
      illegal <= 1'b0;
    end else if (En) begin
      q       <= q_nxt;
      illegal <= ill_nxt;
    end else begin
      illegal <= 1'b0;
    end
  end

endmodule

// File: rtl/universal_ff_reg.sv
// WIDTH-bit register bank of run-time selectable SR/JK/D/T flops with illegal-SR tracking.
// Latency: all outputs registered, one edge; Qn is combinational from Q.
// Backpressure: none; En gates updates, ClrErr always honoured.
module universal_ff_reg
  import uff_pkg::*;
#(
  parameter int               WIDTH   = 4,
  parameter logic [WIDTH-1:0] RST_VAL = '0,
  parameter int               CNT_W   = 8
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             En,
  input  mode_t            Mode,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             ClrErr,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] Qn,
  output logic [WIDTH-1:0] Illegal,
  output logic             IllegalSticky,
  output logic [CNT_W-1:0] IllegalCnt
);

  logic [WIDTH-1:0] conflict;
  logic             ill_evt;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    uff_bit u_bit (
      .Clk     (Clk),
      .Rst     (Rst),
      .En      (En),
      .Mode    (Mode),
      .a       (A[i]),
      .b       (B[i]),
      .rst_val (RST_VAL[i]),
      .q       (Q[i]),
      .illegal (Illegal[i])
    );
    assign conflict[i] = sr_conflict(Mode, A[i], B[i]);
  end

  // Event seen on this edge so sticky/count line up with the Illegal flags they report.
  assign ill_evt = En && (|conflict);
  assign Qn      = ~Q;

  always_ff @(posedge Clk) begin
    if (Rst) begin
      IllegalSticky <= 1'b0;
      IllegalCnt    <= '0;
    end else if (ClrErr) begin
      IllegalSticky <= ill_evt;
      IllegalCnt    <= ill_evt ? CNT_W'(1) : '0;
    end else if (ill_evt) begin
      IllegalSticky <= 1'b1;
      if (IllegalCnt != {CNT_W{1'b1}})
        IllegalCnt <= IllegalCnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_universal_ff_reg.sv
// Directed-vector bench: driver queues expected state per edge, monitor checks after each edge.
module tb_universal_ff_reg;
  import uff_pkg::*;

`ifdef UFF_SR_SET_PRIORITY_EN
  localparam bit SP = 1'b1;
`else
  localparam bit SP = 1'b0;
`endif

  logic       Clk = 1'b0;
  logic       Rst = 1'b1;
  logic       En = 1'b0;
  mode_t      Mode = MODE_D;
  logic [3:0] A = '0;
  logic [3:0] B = '0;
  logic       ClrErr = 1'b0;
  logic [3:0] Q, Qn, Illegal;
  logic       IllegalSticky;
  logic [1:0] IllegalCnt;

  int n_chk  = 0;
  int n_fail = 0;

  universal_ff_reg #(.WIDTH(4), .RST_VAL(4'b1010), .CNT_W(2)) dut (
    .Clk           (Clk),
    .Rst           (Rst),
    .En            (En),
    .Mode          (Mode),
    .A             (A),
    .B             (B),
    .ClrErr        (ClrErr),
    .Q             (Q),
    .Qn            (Qn),
    .Illegal       (Illegal),
    .IllegalSticky (IllegalSticky),
    .IllegalCnt    (IllegalCnt)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    string      name;
    logic [3:0] q;
    logic [3:0] ill;
    logic       st;
    logic [1:0] cnt;
  } exp_t;

  exp_t sbq[$];

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step(input string nm, input logic rst, input logic en, input mode_t m,
                      input logic [3:0] a, input logic [3:0] b, input logic clr,
                      input logic [3:0] eq, input logic [3:0] eill,
                      input logic est, input logic [1:0] ecnt);
    exp_t e;
    @(negedge Clk);
    Rst = rst; En = en; Mode = m; A = a; B = b; ClrErr = clr;
    e.name = nm; e.q = eq; e.ill = eill; e.st = est; e.cnt = ecnt;
    sbq.push_back(e);
    @(posedge Clk);
  endtask

  // Monitor: every edge with a pending expectation is checked 1 time unit later.
  initial begin
    exp_t e;
    forever begin
      @(posedge Clk);
      #1;
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        chk({e.name, ".q"},      {4'b0, Q},             {4'b0, e.q});
        chk({e.name, ".qn"},     {4'b0, Qn},            {4'b0, ~e.q});
        chk({e.name, ".ill"},    {4'b0, Illegal},       {4'b0, e.ill});
        chk({e.name, ".sticky"}, {7'b0, IllegalSticky}, {7'b0, e.st});
        chk({e.name, ".cnt"},    {6'b0, IllegalCnt},    {6'b0, e.cnt});
      end
    end
  end

  initial begin
    logic [3:0] q0;
    // Reset under random inputs, held two edges.
    for (int i = 0; i < 2; i++)
      step("reset", 1, 1, mode_t'($urandom_range(0, 3)), 4'($urandom), 4'($urandom),
           1'($urandom), 4'b1010, 4'b0000, 0, 2'd0);

    // SR from 0000: bit0 conflict, bit1 set, bit2 reset, bit3 hold.
    step("d_clr", 0, 1, MODE_D, 4'b0000, 4'b0000, 0, 4'b0000, 4'b0000, 0, 2'd0);
    step("sr_mix", 0, 1, MODE_SR, 4'b0011, 4'b0101, 0,
         SP ? 4'b0011 : 4'b0010, SP ? 4'b0000 : 4'b0001, !SP, SP ? 2'd0 : 2'd1);
    step("sr_hold", 0, 1, MODE_SR, 4'b0000, 4'b0000, 0,
         SP ? 4'b0011 : 4'b0010, 4'b0000, !SP, SP ? 2'd0 : 2'd1);

    // JK from 0110: bit3 toggle, bit2 set, bit1 reset, bit0 hold.
    step("reset2", 1, 0, MODE_SR, 4'b1111, 4'b1111, 0, 4'b1010, 4'b0000, 0, 2'd0);
    step("d_0110", 0, 1, MODE_D, 4'b0110, 4'b0000, 0, 4'b0110, 4'b0000, 0, 2'd0);
    step("jk_1", 0, 1, MODE_JK, 4'b1100, 4'b1010, 0, 4'b1100, 4'b0000, 0, 2'd0);
    step("jk_2", 0, 1, MODE_JK, 4'b1100, 4'b1010, 0, 4'b0100, 4'b0000, 0, 2'd0);

    // D, T, then disabled T.
    step("d_1001", 0, 1, MODE_D, 4'b1001, 4'b1111, 0, 4'b1001, 4'b0000, 0, 2'd0);
    step("t_1111", 0, 1, MODE_T, 4'b1111, 4'b1111, 0, 4'b0110, 4'b0000, 0, 2'd0);
    step("t_en0", 0, 0, MODE_T, 4'b1111, 4'b0000, 0, 4'b0110, 4'b0000, 0, 2'd0);

    // Saturating counter, clear-with-event, enable-low behaviour.
    step("reset3", 1, 1, MODE_D, 4'b0000, 4'b0000, 0, 4'b1010, 4'b0000, 0, 2'd0);
    step("d_0000", 0, 1, MODE_D, 4'b0000, 4'b0000, 0, 4'b0000, 4'b0000, 0, 2'd0);
    q0 = SP ? 4'b0001 : 4'b0000;
    for (int i = 1; i <= 5; i++)
      step($sformatf("sat_%0d", i), 0, 1, MODE_SR, 4'b0001, 4'b0001, 0,
           q0, SP ? 4'b0000 : 4'b0001, !SP, SP ? 2'd0 : ((i > 3) ? 2'd3 : 2'(i)));
    step("clr_evt", 0, 1, MODE_SR, 4'b0001, 4'b0001, 1,
         q0, SP ? 4'b0000 : 4'b0001, !SP, SP ? 2'd0 : 2'd1);
    step("en0_hold", 0, 0, MODE_SR, 4'b0001, 4'b0001, 0, q0, 4'b0000, !SP, SP ? 2'd0 : 2'd1);
    step("en0_clr", 0, 0, MODE_SR, 4'b0001, 4'b0001, 1, q0, 4'b0000, 0, 2'd0);

    // All four bits illegal on one edge counts once; then reset mid-event.
    step("sr_all", 0, 1, MODE_SR, 4'b1111, 4'b1111, 0,
         SP ? 4'b1111 : q0, SP ? 4'b0000 : 4'b1111, !SP, SP ? 2'd0 : 2'd1);
    step("rst_mid", 1, 1, MODE_SR, 4'b1111, 4'b1111, 0, 4'b1010, 4'b0000, 0, 2'd0);
    step("mode_chg", 0, 1, MODE_T, 4'b0011, 4'b0011, 0, 4'b1001, 4'b0000, 0, 2'd0);

    repeat (3) @(posedge Clk);
    #2;
    chk("sb_drained", 8'(sbq.size()), 8'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
